register_f_reader: RTL and testbench
====================================

// Module: register_f_reader
// PURPOSE
// - Read-side counterpart of the per-bit F-register writers (REGISTER_F_Z and its siblings). It snapshots the live flag
//   bits and assembles them into the F byte, then drives that byte active-low onto the shared result bus.
// - Uses: PUSH AF and the EX AF write-back path. The write side's restore mux loads Z from notALUResult[6], so this byte
//   layout is the layout that mux expects.
// - Also evaluates the 3-bit branch condition code for JP/JR/CALL/RET cc and holds the result stable for the sequencer.
// PARAMETERS
// - HOLD_CYCLES   1      cycles the byte stays driven after the first Ack-free cycle (1..4)
// - FIXED_BITS    8'h00  values for F bits 5 and 3; only those two bits are used, all others are ignored
// PORTS
// - Clk              in   1  system clock, rising edge
// - Reset            in   1  synchronous, active-high
// - F_S,F_Z,F_H      in   1  live flags (true polarity)
// - F_P,F_N,F_C      in   1  live flags (true polarity)
// - PR_Read          in   1  request: snapshot F and drive the bus
// - Ack              in   1  consumer has taken the byte
// - CondReq          in   1  evaluate condition Cc
// - Cc               in   3  0 NZ, 1 Z, 2 NC, 3 C, 4 PO, 5 PE, 6 P, 7 M
// - notFBus          out  8  active-low F byte; bit7 S, 6 Z, 5 FIXED[5], 4 H, 3 FIXED[3], 2 P, 1 N, 0 C
// - FBusValid        out  1  notFBus holds a valid snapshot
// - Busy             out  1  FSM is not in IDLE
// - CondTrue         out  1  registered condition result
// - notCondTrue      out  1  complement of CondTrue
// BEHAVIOUR
// - Reset values: notFBus=8'hFF, FBusValid=0, Busy=0, CondTrue=0, notCondTrue=1, FSM=IDLE, hold counter=0.
// - FSM IDLE: PR_Read=1 captures the flags into the snapshot register at that edge -> DRIVE.
//   Busy and FBusValid rise on the next cycle, so latency is 1 clock from request to valid.
// - FSM DRIVE: notFBus = ~snapshot. Ack=1 -> WAIT, counter loaded with HOLD_CYCLES-1.
// - FSM WAIT: counter decrements each cycle; at 0 -> IDLE. If HOLD_CYCLES=1 the FSM goes DRIVE->IDLE directly on Ack.
// - On IDLE entry: FBusValid=0 and notFBus returns to 8'hFF in the same edge.
// - The snapshot is frozen for the whole transaction. Flag changes after the capture edge never reach the bus,
//   including a write to F landing in the capture cycle.
// - PR_Read while Busy is ignored; no queueing.
// - PR_Read in the cycle the FSM returns to IDLE is not accepted. It must be re-asserted and is taken one cycle later.
// - Ack in IDLE is ignored.
// - Ack held high continuously: DRIVE lasts exactly 1 cycle.
// - Condition evaluation is independent of the FSM and may overlap a bus transaction.
//   - CondReq=1: CondTrue <= f(Cc, live flags) at that edge.
//   - Even cc tests flag==0, odd cc tests flag==1. Flag per cc pair: 0/1 Z, 2/3 C, 4/5 P, 6/7 S.
//   - CondReq=0: CondTrue holds its value.
//   - notCondTrue is always the exact complement of CondTrue, with no cycle where both are equal.
// - Simultaneous PR_Read and CondReq: both are served in the same edge and both read the same pre-edge flag values.
// - Reset mid-transaction: the next edge forces the reset values. The snapshot is cleared to 0.
// CONFIGURATION
// - REGISTER_F_SHADOW_READ_EN defined: adds inputs notShadowF_S, notShadowF_Z, notShadowF_H, notShadowF_P,
//   notShadowF_N, notShadowF_C (active-low) and ReadShadow (1 bit).
//   - ReadShadow=1 at the capture edge snapshots the inverted shadow set instead of the live set.
//   - ReadShadow is sampled only at the capture edge.
//   - CondTrue always uses the live set.
// - Macro undefined: the shadow ports do not exist and the live set is always captured.
// TESTING
// - Reset, then live S=1 Z=1 H=0 P=1 N=0 C=1, PR_Read pulse
//   -> next cycle FBusValid=1, notFBus=~8'hC5=8'h3A, Busy=1.
// - In DRIVE, flip Z to 0 and hold Ack=0 for 5 cycles
//   -> notFBus stays 8'h3A; Ack, then HOLD_CYCLES=1 -> next cycle FBusValid=0, notFBus=8'hFF.
// - Sweep Cc 0..7 with CondReq, flags Z=1 C=0 P=1 S=0
//   -> CondTrue sequence 0,1,1,0,0,1,1,0; notCondTrue always the complement.
// - PR_Read while Busy; PR_Read in the cycle the FSM returns to IDLE
//   -> both ignored, no second capture; re-assert -> captured one cycle later.
// - Reset asserted in WAIT with HOLD_CYCLES=3
//   -> next cycle all outputs at reset values, FSM IDLE, new PR_Read accepted.
// - REGISTER_F_SHADOW_READ_EN: shadow active-low inputs = 8'b...(S=0 Z=1 others 0), ReadShadow=1, PR_Read
//   -> notFBus=8'hBF; CondTrue for cc=1 still follows live Z.

Source files
------------

// File: rtl/register_f_reader_if.sv
// Bus-side handshake for the F-register reader: request/acknowledge from the
// consumer, active-low F byte plus status back from the reader.
interface register_f_reader_if;
  logic       PR_Read;
  logic       Ack;
  logic [7:0] notFBus;
  logic       FBusValid;
  logic       Busy;

  modport master (
    output PR_Read,
    output Ack,
    input  notFBus,
    input  FBusValid,
    input  Busy
  );

  modport slave (
    input  PR_Read,
    input  Ack,
    output notFBus,
    output FBusValid,
    output Busy
  );
endinterface

// File: rtl/register_f_reader.sv
// register_f_reader: snapshots the live flags into the F byte layout the
// write-side restore mux expects (S Z F5 H F3 P N C) and drives it active-low
// onto the shared result bus under a request/ack handshake. Also evaluates the
// 3-bit branch condition code and holds the registered result.
// Optional feature macro: REGISTER_F_SHADOW_READ_EN (adds the active-low shadow
// flag inputs and ReadShadow select, sampled only at the capture edge).
module register_f_reader #(
  parameter int          HOLD_CYCLES = 1,
  parameter logic [7:0]  FIXED_BITS  = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       F_S,
  input  logic       F_Z,
  input  logic       F_H,
  input  logic       F_P,
  input  logic       F_N,
  input  logic       F_C,
  input  logic       CondReq,
  input  logic [2:0] Cc,
  output logic       CondTrue,
  output logic       notCondTrue,
`ifdef REGISTER_F_SHADOW_READ_EN
  input  logic       notShadowF_S,
  input  logic       notShadowF_Z,
  input  logic       notShadowF_H,
  input  logic       notShadowF_P,
  input  logic       notShadowF_N,
  input  logic       notShadowF_C,
  input  logic       ReadShadow,
`endif
  register_f_reader_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // Counter reload on Ack; zero means the FSM returns straight to IDLE.
  localparam logic [2:0] HOLD_LOAD = 3'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] hold_cnt;
  logic [7:0] snap;
  logic [7:0] capture_f;
  logic       cond_true;

  // Bits 5 and 3 come from FIXED_BITS; everything else is the flag set.
  function automatic logic [7:0] pack_f(input logic s, input logic z, input logic h,
                                        input logic p, input logic n, input logic c);
    return {s, z, FIXED_BITS[5], h, FIXED_BITS[3], p, n, c};
  endfunction

  // Even codes test flag==0, odd codes test flag==1; pairs select Z, C, P, S.
  function automatic logic eval_cc(input logic [2:0] cc, input logic s, input logic z,
                                   input logic p, input logic c);
    logic flag;
    case (cc[2:1])
      2'd0:    flag = z;
      2'd1:    flag = c;
      2'd2:    flag = p;
      default: flag = s;
    endcase
    return cc[0] ? flag : ~flag;
  endfunction

  // Select which flag set lands in the snapshot at the capture edge.
  always_comb begin
    capture_f = pack_f(F_S, F_Z, F_H, F_P, F_N, F_C);
`ifdef REGISTER_F_SHADOW_READ_EN
    if (ReadShadow) begin
      capture_f = pack_f(~notShadowF_S, ~notShadowF_Z, ~notShadowF_H,
                         ~notShadowF_P, ~notShadowF_N, ~notShadowF_C);
    end
`endif
  end

  // Transaction FSM: capture in IDLE, drive until Ack, then hold for the tail.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      hold_cnt <= 3'd0;
      snap     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.PR_Read) begin
            snap  <= capture_f;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (bus.Ack) begin
            hold_cnt <= HOLD_LOAD;
            if (HOLD_LOAD == 3'd0) begin
              state <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          hold_cnt <= hold_cnt - 3'd1;
          if (hold_cnt <= 3'd1) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Branch condition register, independent of the bus transaction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cond_true <= 1'b0;
    end else if (CondReq) begin
      cond_true <= eval_cc(Cc, F_S, F_Z, F_P, F_C);
    end
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.FBusValid = (state != IDLE);
  assign bus.notFBus   = (state != IDLE) ? ~snap : 8'hFF;
  assign CondTrue      = cond_true;
  assign notCondTrue   = ~cond_true;

endmodule

// File: tb/tb_register_f_reader.sv
// Directed bench for register_f_reader: one instance with HOLD_CYCLES=1 and one
// with HOLD_CYCLES=3 sharing clock, reset and flags.
module tb_register_f_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       f_s, f_z, f_h, f_p, f_n, f_c;
  logic       cond_req, cond_req3;
  logic [2:0] cc;
  logic       cond_true, not_cond_true, cond_true3, not_cond_true3;
`ifdef REGISTER_F_SHADOW_READ_EN
  logic       n_sh_s, n_sh_z, n_sh_h, n_sh_p, n_sh_n, n_sh_c, read_shadow;
`endif

  int checks = 0;
  int errors = 0;

  register_f_reader_if bus1 ();
  register_f_reader_if bus3 ();

  always #5 clk = ~clk;

  register_f_reader #(.HOLD_CYCLES(1), .FIXED_BITS(8'h00)) u_dut1 (
    .Clk(clk), .Reset(rst),
    .F_S(f_s), .F_Z(f_z), .F_H(f_h), .F_P(f_p), .F_N(f_n), .F_C(f_c),
    .CondReq(cond_req), .Cc(cc), .CondTrue(cond_true), .notCondTrue(not_cond_true),
`ifdef REGISTER_F_SHADOW_READ_EN
    .notShadowF_S(n_sh_s), .notShadowF_Z(n_sh_z), .notShadowF_H(n_sh_h),
    .notShadowF_P(n_sh_p), .notShadowF_N(n_sh_n), .notShadowF_C(n_sh_c),
    .ReadShadow(read_shadow),
`endif
    .bus(bus1.slave)
  );

  register_f_reader #(.HOLD_CYCLES(3), .FIXED_BITS(8'h00)) u_dut3 (
    .Clk(clk), .Reset(rst),
    .F_S(f_s), .F_Z(f_z), .F_H(f_h), .F_P(f_p), .F_N(f_n), .F_C(f_c),
    .CondReq(cond_req3), .Cc(cc), .CondTrue(cond_true3), .notCondTrue(not_cond_true3),
`ifdef REGISTER_F_SHADOW_READ_EN
    .notShadowF_S(n_sh_s), .notShadowF_Z(n_sh_z), .notShadowF_H(n_sh_h),
    .notShadowF_P(n_sh_p), .notShadowF_N(n_sh_n), .notShadowF_C(n_sh_c),
    .ReadShadow(read_shadow),
`endif
    .bus(bus3.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic s, input logic z, input logic h,
                           input logic p, input logic n, input logic c);
    f_s = s; f_z = z; f_h = h; f_p = p; f_n = n; f_c = c;
  endtask

  logic [7:0] cc_exp;

  initial begin
    rst = 1'b1;
    set_flags(0, 0, 0, 0, 0, 0);
    cond_req = 0; cond_req3 = 0; cc = 3'd0;
    bus1.PR_Read = 0; bus1.Ack = 0;
    bus3.PR_Read = 0; bus3.Ack = 0;
`ifdef REGISTER_F_SHADOW_READ_EN
    {n_sh_s, n_sh_z, n_sh_h, n_sh_p, n_sh_n, n_sh_c} = 6'b111111;
    read_shadow = 0;
`endif
    step();
    step();
    rst = 1'b0;

    // Reset values
    chk("rst_notFBus",     bus1.notFBus, 8'hFF);
    chk("rst_valid",       {7'd0, bus1.FBusValid}, 8'h00);
    chk("rst_busy",        {7'd0, bus1.Busy}, 8'h00);
    chk("rst_condtrue",    {7'd0, cond_true}, 8'h00);
    chk("rst_notcondtrue", {7'd0, not_cond_true}, 8'h01);

    // Capture S=1 Z=1 H=0 P=1 N=0 C=1 -> F=C5, bus=3A one cycle later
    set_flags(1, 1, 0, 1, 0, 1);
    bus1.PR_Read = 1;
    step();
    bus1.PR_Read = 0;
    chk("cap_valid",   {7'd0, bus1.FBusValid}, 8'h01);
    chk("cap_notFBus", bus1.notFBus, 8'h3A);
    chk("cap_busy",    {7'd0, bus1.Busy}, 8'h01);

    // Z flips, Ack low for 5 cycles, PR_Read while busy: bus frozen
    f_z = 0;
    bus1.PR_Read = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_notFBus", bus1.notFBus, 8'h3A);
      chk("hold_valid",   {7'd0, bus1.FBusValid}, 8'h01);
    end

    // Ack with PR_Read still high in the returning cycle: not accepted
    bus1.Ack = 1;
    step();
    chk("ret_valid",   {7'd0, bus1.FBusValid}, 8'h00);
    chk("ret_notFBus", bus1.notFBus, 8'hFF);
    chk("ret_busy",    {7'd0, bus1.Busy}, 8'h00);

    // PR_Read still asserted: taken one cycle later with S=1 Z=0 P=1 C=1 -> F=85, bus=7A
    bus1.Ack = 0;
    step();
    bus1.PR_Read = 0;
    chk("recap_notFBus", bus1.notFBus, 8'h7A);

    // Ack held high continuously: DRIVE lasts exactly one cycle
    bus1.Ack = 1;
    step();
    chk("ackhold_valid",   {7'd0, bus1.FBusValid}, 8'h00);
    chk("ackhold_notFBus", bus1.notFBus, 8'hFF);
    step();
    chk("ack_idle_ignored", {7'd0, bus1.Busy}, 8'h00);
    bus1.Ack = 0;

    // Condition sweep with Z=1 C=0 P=1 S=0 -> 0,1,1,0,0,1,1,0
    set_flags(0, 1, 0, 1, 0, 0);
    cc_exp = 8'b0110_0110;
    cond_req = 1;
    for (int i = 0; i < 8; i++) begin
      cc = 3'(i);
      step();
      chk("cc_sweep",    {7'd0, cond_true}, {7'd0, cc_exp[i]});
      chk("cc_sweep_n",  {7'd0, not_cond_true}, {7'd0, ~cc_exp[i]});
    end

    // CondReq low: result holds even though M would now be true
    cond_req = 0;
    f_s = 1;
    step();
    chk("cc_hold", {7'd0, cond_true}, 8'h00);

    // Simultaneous capture and condition: S1 Z1 H1 P0 N1 C0 -> F=D2, bus=2D, Z true
    set_flags(1, 1, 1, 0, 1, 0);
    bus1.PR_Read = 1;
    cond_req = 1;
    cc = 3'd1;
    step();
    bus1.PR_Read = 0;
    cond_req = 0;
    set_flags(0, 0, 0, 0, 0, 0);
    chk("simul_notFBus", bus1.notFBus, 8'h2D);
    chk("simul_cond",    {7'd0, cond_true}, 8'h01);
    step();
    chk("simul_frozen",  bus1.notFBus, 8'h2D);
    bus1.Ack = 1;
    step();
    bus1.Ack = 0;
    chk("simul_idle", bus1.notFBus, 8'hFF);

    // HOLD_CYCLES=3: full transaction, two WAIT cycles after Ack
    set_flags(0, 0, 0, 0, 0, 1);
    bus3.PR_Read = 1;
    step();
    bus3.PR_Read = 0;
    chk("h3_notFBus", bus3.notFBus, 8'hFE);
    bus3.Ack = 1;
    step();
    bus3.Ack = 0;
    chk("h3_wait1_valid", {7'd0, bus3.FBusValid}, 8'h01);
    step();
    chk("h3_wait2_valid", {7'd0, bus3.FBusValid}, 8'h01);
    step();
    chk("h3_idle_valid", {7'd0, bus3.FBusValid}, 8'h00);

    // HOLD_CYCLES=3: reset asserted in WAIT
    bus3.PR_Read = 1;
    step();
    bus3.PR_Read = 0;
    bus3.Ack = 1;
    step();
    bus3.Ack = 0;
    chk("h3_in_wait", {7'd0, bus3.Busy}, 8'h01);
    rst = 1;
    step();
    rst = 0;
    chk("h3_rst_busy",    {7'd0, bus3.Busy}, 8'h00);
    chk("h3_rst_valid",   {7'd0, bus3.FBusValid}, 8'h00);
    chk("h3_rst_notFBus", bus3.notFBus, 8'hFF);
    chk("h3_rst_cond",    {7'd0, cond_true}, 8'h00);
    chk("h3_rst_ncond",   {7'd0, not_cond_true}, 8'h01);
    set_flags(1, 0, 0, 0, 0, 0);
    bus3.PR_Read = 1;
    step();
    bus3.PR_Read = 0;
    chk("h3_after_rst", bus3.notFBus, 8'h7F);
    rst = 1;
    step();
    rst = 0;

`ifdef REGISTER_F_SHADOW_READ_EN
    // Shadow read: shadow Z=1 only (active-low inputs) -> bus BF; condition uses live Z=0
    set_flags(0, 0, 0, 0, 0, 0);
    {n_sh_s, n_sh_z, n_sh_h, n_sh_p, n_sh_n, n_sh_c} = 6'b101111;
    read_shadow = 1;
    bus1.PR_Read = 1;
    cond_req = 1;
    cc = 3'd1;
    step();
    bus1.PR_Read = 0;
    cond_req = 0;
    read_shadow = 0;
    chk("shadow_notFBus", bus1.notFBus, 8'hBF);
    chk("shadow_cond",    {7'd0, cond_true}, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
